debounce_fsm: RTL and testbench

//   Cleans a raw mechanical switch/button input into a glitch-free level for the

---
 rtl/debounce_fsm.sv | 68 ++++++
 tb/tb_debounce_fsm.sv | 127 ++++++++++++
 2 files changed

// File: rtl/debounce_fsm.sv
// debounce_fsm: synchronise a bouncing switch and qualify level changes over STABLE_CYCLES+1 samples
module debounce_fsm #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic sw,
    output logic db_level,
    output logic db_rise_tick,
    output logic db_fall_tick,
    output logic busy
);
    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {ZERO, WAIT1, ONE, WAIT0} state_t;

    state_t                 state, state_nx;
    logic [CNT_W-1:0]       cnt, cnt_nx;
    logic [SYNC_STAGES-1:0] sync;
    logic                   sw_s;

    assign sw_s = sync[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge reset)
        if (reset) sync <= '0;
        else       sync <= {sync[SYNC_STAGES-2:0], sw};

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state        <= ZERO;
            cnt          <= '0;
            db_rise_tick <= 1'b0;
            db_fall_tick <= 1'b0;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            db_rise_tick <= (state == WAIT1) && (state_nx == ONE);
            db_fall_tick <= (state == WAIT0) && (state_nx == ZERO);
        end

    // A disagreeing sample during qualification drops straight back to the prior level.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            ZERO:  if (sw_s) begin
                       state_nx = WAIT1;
                       cnt_nx   = CNT_LOAD;
                   end
            WAIT1: if (!sw_s)          state_nx = ZERO;
                   else if (cnt == '0) state_nx = ONE;
                   else                cnt_nx   = cnt - CNT_W'(1);
            ONE:   if (!sw_s) begin
                       state_nx = WAIT0;
                       cnt_nx   = CNT_LOAD;
                   end
            WAIT0: if (sw_s)           state_nx = ONE;
                   else if (cnt == '0) state_nx = ZERO;
                   else                cnt_nx   = cnt - CNT_W'(1);
            default:                   state_nx = ZERO;
        endcase
    end

    assign db_level = (state == ONE) || (state == WAIT0);
    assign busy     = (state == WAIT1) || (state == WAIT0);
endmodule

// File: tb/tb_debounce_fsm.sv
// tb_debounce_fsm: directed scoreboard bench for debounce_fsm (default instance and STABLE_CYCLES=1 instance)
module tb_debounce_fsm;
    logic clk = 1'b0;
    logic reset, sw, sw2;
    logic lvl, rise, fall, bsy;
    logic lvl2, rise2, fall2, bsy2;
    int   checks = 0;
    int   failures = 0;
    string tag = "init";
    logic [3:0] sb[$];

    always #5 clk = ~clk;

    debounce_fsm dut (
        .clk(clk), .reset(reset), .sw(sw),
        .db_level(lvl), .db_rise_tick(rise), .db_fall_tick(fall), .busy(bsy)
    );

    debounce_fsm #(.SYNC_STAGES(2), .STABLE_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .sw(sw2),
        .db_level(lvl2), .db_rise_tick(rise2), .db_fall_tick(fall2), .busy(bsy2)
    );

    // Expected words are {db_level, db_rise_tick, db_fall_tick, busy}.
    task automatic chk(input bit d, input logic [3:0] want);
        logic [3:0] got;
        got = d ? {lvl2, rise2, fall2, bsy2} : {lvl, rise, fall, bsy};
        checks++;
        assert (got === want) else begin
            failures++;
            $error("FAIL %s dut%0d t=%0t observed=%b expected=%b", tag, d, $time, got, want);
        end
    endtask

    task automatic step(input bit d, input logic s, input logic [3:0] e);
        if (d) sw2 = s;
        else   sw  = s;
        sb.push_back(e);
        @(posedge clk);
        #1;
        chk(d, sb.pop_front());
    endtask

    task automatic run(input bit d, input logic s, input int n, input logic [3:0] e);
        repeat (n) step(d, s, e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog t=%0t observed=running expected=finished", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0; sw = 1'b0; sw2 = 1'b0;
        #2 reset = 1'b1;
        #1 tag = "reset_state";
        chk(0, 4'b0000);
        chk(1, 4'b0000);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        tag = "idle_after_reset";
        run(0, 1'b0, 20, 4'b0000);

        tag = "pulse4_rejected";
        run(0, 1'b1, 2, 4'b0000);
        run(0, 1'b1, 2, 4'b0001);
        run(0, 1'b0, 2, 4'b0001);
        run(0, 1'b0, 6, 4'b0000);

        tag = "pulse5_accepted";
        run(0, 1'b1, 2, 4'b0000);
        run(0, 1'b1, 3, 4'b0001);
        run(0, 1'b0, 1, 4'b0001);
        run(0, 1'b0, 1, 4'b1100);
        run(0, 1'b0, 4, 4'b1001);
        run(0, 1'b0, 1, 4'b0010);
        run(0, 1'b0, 3, 4'b0000);

        tag = "rise_latency";
        run(0, 1'b1, 2, 4'b0000);
        run(0, 1'b1, 4, 4'b0001);
        run(0, 1'b1, 1, 4'b1100);
        run(0, 1'b1, 5, 4'b1000);

        tag = "bounce_hold_high";
        for (int i = 0; i < 10; i++)
            run(0, logic'(i[0]), 2, {3'b100, logic'(i[0])});
        tag = "bounce_fall";
        run(0, 1'b0, 2, 4'b1000);
        run(0, 1'b0, 4, 4'b1001);
        run(0, 1'b0, 1, 4'b0010);
        run(0, 1'b0, 3, 4'b0000);

        tag = "reset_mid_wait1";
        run(0, 1'b1, 2, 4'b0000);
        run(0, 1'b1, 2, 4'b0001);
        reset = 1'b1;
        #1 chk(0, 4'b0000);
        repeat (2) @(posedge clk);
        #1 chk(0, 4'b0000);
        reset = 1'b0;
        tag = "rise_after_reset";
        run(0, 1'b1, 2, 4'b0000);
        run(0, 1'b1, 4, 4'b0001);
        run(0, 1'b1, 1, 4'b1100);
        run(0, 1'b1, 3, 4'b1000);

        tag = "s1_pulse1_rejected";
        run(1, 1'b1, 1, 4'b0000);
        run(1, 1'b0, 1, 4'b0000);
        run(1, 1'b0, 1, 4'b0001);
        run(1, 1'b0, 4, 4'b0000);

        tag = "s1_pulse2_accepted";
        run(1, 1'b1, 2, 4'b0000);
        run(1, 1'b0, 1, 4'b0001);
        run(1, 1'b0, 1, 4'b1100);
        run(1, 1'b0, 1, 4'b1001);
        run(1, 1'b0, 1, 4'b0010);
        run(1, 1'b0, 3, 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
